// File: rtl/fir_pkg.sv
// Shared types and constants for the folded FIR sequencer: widths, state enum,
// clog2 helper and the default 63-tap lowpass coefficient set.
package fir_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 32;
  localparam int N63    = 63;

  typedef logic signed [DW_DEF-1:0] coef_t;

  typedef enum logic [1:0] {IDLE, MAC, FLUSH, OUT} state_t;

  // Width needed to index v entries; never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Triangular (Bartlett) lowpass, symmetric about tap 31; element 0 in the MSBs.
  function automatic logic [N63*DW_DEF-1:0] coef63_gen();
    logic [N63*DW_DEF-1:0] v;
    int d;
    v = '0;
    for (int i = 0; i < N63; i++) begin
      d = (i > 31) ? i - 31 : 31 - i;
      v[(N63-1-i)*DW_DEF +: DW_DEF] = coef_t'((32 - d) * 64);
    end
    return v;
  endfunction

  localparam logic [N63*DW_DEF-1:0] FIR_PKG_COEF63 = coef63_gen();

endpackage

// File: rtl/fir_mac_unit.sv
// Shared multiplier plus accumulator: registered AW-bit signed product, and an
// accumulator that adds the previous product and wraps modulo 2^AW.
module fir_mac_unit import fir_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 mul_en,
  input  logic                 add_en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);

  logic signed [AW-1:0] prod, a_x, b_x;

  // Operands are sign-extended so the AW-bit product is exact modulo 2^AW.
  assign a_x = AW'(a);
  assign b_x = AW'(b);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (mul_en) prod <= a_x * b_x;
      if (add_en) acc  <= acc + prod;
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Folded N-tap FIR: one shared MAC stepped over all taps per sample.
// Build with FIR_SEQ_COEF_WR_EN for run-time writable coefficients.
module fir_mac_sequencer import fir_pkg::*; #(
  parameter int              N    = 63,
  parameter int              DW   = DW_DEF,
  parameter int              AW   = AW_DEF,
  parameter logic [N*DW-1:0] COEF = FIR_PKG_COEF63,
  localparam int             PW   = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] y_out,
`ifdef FIR_SEQ_COEF_WR_EN
  input  logic                 coef_wr_en,
  input  logic [PW-1:0]        coef_wr_addr,
  input  logic signed [DW-1:0] coef_wr_data,
  output logic                 coef_wr_ready,
`endif
  output logic                 busy
);

  state_t               state, state_nx;
  logic [PW-1:0]        wr_ptr, rd_ptr, k;
  logic signed [DW-1:0] sbuf     [N];
  logic signed [DW-1:0] coef_arr [N];
  logic                 in_hs, out_hs, clr, mul_en, add_en;
  logic signed [AW-1:0] acc;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

`ifdef FIR_SEQ_COEF_WR_EN
  assign coef_wr_ready = in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) coef_arr[i] <= COEF[(N-1-i)*DW +: DW];
    end else if (coef_wr_en && coef_wr_ready && (int'(coef_wr_addr) < N)) begin
      coef_arr[coef_wr_addr] <= coef_wr_data;
    end
  end
`else
  for (genvar i = 0; i < N; i++) begin : g_coef
    assign coef_arr[i] = COEF[(N-1-i)*DW +: DW];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    mul_en   = 1'b0;
    add_en   = 1'b0;
    unique case (state)
      IDLE: if (in_hs) begin
        state_nx = MAC;
        clr      = 1'b1;
      end
      MAC: begin
        // Product from the previous tap lands one cycle late; tap 0 adds nothing.
        mul_en = 1'b1;
        add_en = (k != '0);
        if (k == PW'(N-1)) state_nx = FLUSH;
      end
      FLUSH: begin
        add_en   = 1'b1;
        state_nx = OUT;
      end
      OUT: if (out_hs) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) sbuf[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      y_out     <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready <= (state_nx == IDLE);
      busy     <= (state_nx == MAC) || (state_nx == FLUSH);
      unique case (state)
        IDLE: if (in_hs) begin
          sbuf[wr_ptr] <= x_in;
          rd_ptr       <= wr_ptr;
          k            <= '0;
        end
        MAC: begin
          rd_ptr <= (rd_ptr == '0) ? PW'(N-1) : rd_ptr - 1'b1;
          if (k != PW'(N-1)) k <= k + 1'b1;
        end
        FLUSH: wr_ptr <= (wr_ptr == PW'(N-1)) ? '0 : wr_ptr + 1'b1;
        OUT: begin
          // First OUT cycle captures the settled accumulator.
          if (!out_valid) begin
            out_valid <= 1'b1;
            y_out     <= acc;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  fir_mac_unit #(.DW(DW), .AW(AW)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .mul_en (mul_en),
    .add_en (add_en),
    .a      (coef_arr[k]),
    .b      (sbuf[rd_ptr]),
    .acc    (acc)
  );

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: reference model feeds a scoreboard
// queue per DUT; outputs are popped and compared at each output handshake.
module tb_fir_mac_sequencer;
  import fir_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int PW = clog2(N);
  localparam logic [N*DW-1:0] COEF_A = 64'h0001_0002_0003_0004;
  localparam logic [N*DW-1:0] COEF_B = {4{16'h7FFF}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic signed [DW-1:0] a_x, b_x;
  logic signed [AW-1:0] a_y, b_y;
`ifdef FIR_SEQ_COEF_WR_EN
  logic a_cwe, a_cwr, b_cwe, b_cwr;
  logic [PW-1:0] a_cwa, b_cwa;
  logic signed [DW-1:0] a_cwd, b_cwd;
`endif

  fir_mac_sequencer #(.N(N), .DW(DW), .AW(AW), .COEF(COEF_A)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .x_in(a_x),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .y_out(a_y),
`ifdef FIR_SEQ_COEF_WR_EN
    .coef_wr_en(a_cwe), .coef_wr_addr(a_cwa), .coef_wr_data(a_cwd), .coef_wr_ready(a_cwr),
`endif
    .busy(a_busy)
  );

  fir_mac_sequencer #(.N(N), .DW(DW), .AW(AW), .COEF(COEF_B)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .x_in(b_x),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .y_out(b_y),
`ifdef FIR_SEQ_COEF_WR_EN
    .coef_wr_en(b_cwe), .coef_wr_addr(b_cwa), .coef_wr_data(b_cwd), .coef_wr_ready(b_cwr),
`endif
    .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;
  logic signed [AW-1:0] qa[$], qb[$];
  logic [N*DW-1:0] hist_a = '0, hist_b = '0, coef_a = COEF_A;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Direct-form reference: y = sum coef[k] * x[n-k], newest sample in the MSB slot.
  function automatic logic signed [AW-1:0] fir_ref(input logic [N*DW-1:0] c, input logic [N*DW-1:0] h);
    longint s;
    logic signed [DW-1:0] ck, hk;
    s = 0;
    for (int k = 0; k < N; k++) begin
      ck = c[(N-1-k)*DW +: DW];
      hk = h[(N-1-k)*DW +: DW];
      s += longint'(ck) * longint'(hk);
    end
    return AW'(s);
  endfunction

  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      checks++;
      assert (qa.size() != 0) else begin
        errors++;
        $error("FAIL a_unexpected observed=%0h expected=none", a_y);
      end
      if (qa.size() != 0) check("a_y", a_y, qa.pop_front());
    end
    if (b_out_valid && b_out_ready) begin
      checks++;
      assert (qb.size() != 0) else begin
        errors++;
        $error("FAIL b_unexpected observed=%0h expected=none", b_y);
      end
      if (qb.size() != 0) check("b_y", b_y, qb.pop_front());
    end
  end

  task automatic send_a(input logic signed [DW-1:0] x, input bit lat);
    int n;
    n = 0;
    a_x = x;
    a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && n < 100) begin @(negedge clk); n++; end
    check("a_in_wait_ok", 32'(n < 100), 1);
    if (n >= 100) begin a_in_valid = 1'b0; return; end
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    hist_a = {x, hist_a[N*DW-1:DW]};
    qa.push_back(fir_ref(coef_a, hist_a));
    if (lat) begin
      repeat (N+1) @(posedge clk);
      #1 check("lat_low", a_out_valid, 0);
      @(posedge clk);
      #1 check("lat_high", a_out_valid, 1);
    end
  endtask

  task automatic send_b(input logic signed [DW-1:0] x);
    int n;
    n = 0;
    b_x = x;
    b_in_valid = 1'b1;
    @(negedge clk);
    while (!b_in_ready && n < 100) begin @(negedge clk); n++; end
    check("b_in_wait_ok", 32'(n < 100), 1);
    if (n >= 100) begin b_in_valid = 1'b0; return; end
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    hist_b = {x, hist_b[N*DW-1:DW]};
    qb.push_back(fir_ref(COEF_B, hist_b));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || !a_in_ready || !b_in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_ok", 32'(n < 300), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    qa.delete();
    qb.delete();
    hist_a = '0;
    hist_b = '0;
    coef_a = COEF_A;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic signed [AW-1:0] exp_bp;
    int n;
    a_in_valid = 0; b_in_valid = 0; a_x = '0; b_x = '0;
    a_out_ready = 1; b_out_ready = 1;
`ifdef FIR_SEQ_COEF_WR_EN
    a_cwe = 0; a_cwa = '0; a_cwd = '0;
    b_cwe = 0; b_cwa = '0; b_cwd = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_y", a_y, 0);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_busy", a_busy, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Impulse with latency check on every sample
    send_a(16'sd1, 1); send_a(16'sd0, 1); send_a(16'sd0, 1); send_a(16'sd0, 1);
    drain();

    // Step from a cleared history
    do_reset();
    for (int i = 0; i < 5; i++) send_a(16'sd10, 0);
    drain();
    check("step_last_y", a_y, 100);

    // Backpressure: result held while out_ready is low
    a_out_ready = 1'b0;
    send_a(-16'sd3, 0);
    exp_bp = qa[qa.size()-1];
    n = 0;
    @(negedge clk);
    while (!a_out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_wait_ok", 32'(n < 50), 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", a_out_valid, 1);
      check("bp_y", a_y, exp_bp);
      check("bp_in_ready", a_in_ready, 0);
      check("bp_busy", a_busy, 0);
    end
    @(posedge clk);
    #1 a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_post_valid", a_out_valid, 0);
    check("bp_post_y", a_y, exp_bp);
    check("bp_post_in_ready", a_in_ready, 1);
    drain();

    // Reset during MAC aborts; buffer comes back cleared
    send_a(16'sd7, 0);
    @(posedge clk);
    #1 check("mac_busy", a_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", a_out_valid, 0);
    check("abort_y", a_y, 0);
    check("abort_busy", a_busy, 0);
    check("abort_in_ready", a_in_ready, 0);
    qa.delete();
    hist_a = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_a(16'sd1, 0); send_a(16'sd0, 0); send_a(16'sd0, 0); send_a(16'sd0, 0);
    drain();
    check("abort_impulse_last", a_y, 4);

    // Accumulator wraps with no saturation
    for (int i = 0; i < 4; i++) send_b(16'sh7FFF);
    drain();
    check("wrap_y", b_y, 32'hFFFC0004);

`ifdef FIR_SEQ_COEF_WR_EN
    do_reset();
    drain();
    check("cw_ready", a_cwr, 1);
    a_cwe = 1'b1; a_cwa = '0; a_cwd = -16'sd5;
    @(posedge clk);
    #1 a_cwe = 1'b0;
    coef_a[(N-1)*DW +: DW] = -16'sd5;
    send_a(16'sd1, 0);
    check("cw_busy_ready", a_cwr, 0);
    a_cwe = 1'b1; a_cwa = PW'(1); a_cwd = 16'sd99;
    repeat (2) @(posedge clk);
    #1 a_cwe = 1'b0;
    drain();
    check("cw_y", a_y, -32'sd5);
    send_a(16'sd0, 0);
    drain();
    check("cw_dropped_y", a_y, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
